// File: rtl/mxm_operand_streamer.sv
// Operand feeder for the serial MAC/ReLU datapath: loads an activation vector, walks the
// weight memory row-major emitting aligned (weight, activation) pairs, then drains row results.
module mxm_operand_streamer #(
  parameter int unsigned W    = 8,
  parameter int unsigned NMAX = 16,
  parameter int unsigned AW   = 8,
  parameter int unsigned CW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_nin,
  input  logic [CW-1:0] cfg_nout,
  input  logic          x_valid,
  input  logic [W-1:0]  x_data,
  output logic          x_ready,
  output logic          w_rd,
  output logic [AW-1:0] w_addr,
  input  logic [W-1:0]  w_data,
  output logic          pair_valid,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  x_out,
  output logic          row_first,
  output logic          row_last,
  input  logic          y_valid,
  input  logic [W-1:0]  y_data,
  output logic          r_valid,
  output logic [W-1:0]  r_data,
  input  logic          r_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned IW = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam logic [CW-1:0] NMaxC = CW'(NMAX);

  typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StUnload} state_e;

  state_e        state_q;
  logic [CW-1:0] nin_q, nout_q;
  logic [CW-1:0] ld_cnt_q, n_q, m_q, k_q, j_q;
  logic [AW-1:0] w_addr_q;
  logic          pair_valid_q, row_first_q, row_last_q;
  logic [W-1:0]  x_out_q;

  logic [W-1:0]  xbuf [NMAX];
  logic [W-1:0]  ybuf [NMAX];

  logic cfg_legal, last_col, last_row, x_hs, capture, last_res;

  assign cfg_legal = (cfg_nin != '0) && (cfg_nin <= NMaxC) &&
                     (cfg_nout != '0) && (cfg_nout <= NMaxC);
  assign last_col  = (n_q == nin_q - CW'(1));
  assign last_row  = (m_q == nout_q - CW'(1));
  assign x_hs      = x_valid && (state_q == StLoad);
  // Results beyond nout are dropped once the buffer is full.
  assign capture   = y_valid && ((state_q == StStream) || (state_q == StDrain)) &&
                     (k_q != nout_q);
  assign last_res  = (j_q == nout_q - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      nin_q        <= '0;
      nout_q       <= '0;
      ld_cnt_q     <= '0;
      n_q          <= '0;
      m_q          <= '0;
      k_q          <= '0;
      j_q          <= '0;
      w_addr_q     <= '0;
      pair_valid_q <= 1'b0;
      row_first_q  <= 1'b0;
      row_last_q   <= 1'b0;
      x_out_q      <= '0;
    end else begin
      // Pair outputs trail the w_rd cycle by one, matching the memory read latency.
      pair_valid_q <= 1'b0;
      row_first_q  <= 1'b0;
      row_last_q   <= 1'b0;
      x_out_q      <= '0;
      if (capture) k_q <= k_q + CW'(1);

      unique case (state_q)
        StIdle: begin
          if (start && cfg_legal) begin
            nin_q    <= cfg_nin;
            nout_q   <= cfg_nout;
            ld_cnt_q <= '0;
            k_q      <= '0;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          if (x_valid) begin
            ld_cnt_q <= ld_cnt_q + CW'(1);
            if (ld_cnt_q == nin_q - CW'(1)) begin
              n_q      <= '0;
              m_q      <= '0;
              w_addr_q <= '0;
              state_q  <= StStream;
            end
          end
        end
        StStream: begin
          pair_valid_q <= 1'b1;
          x_out_q      <= xbuf[n_q[IW-1:0]];
          row_first_q  <= (n_q == '0);
          row_last_q   <= last_col;
          w_addr_q     <= w_addr_q + AW'(1);
          if (last_col) begin
            n_q <= '0;
            m_q <= m_q + CW'(1);
            if (last_row) begin
              w_addr_q <= '0;
              state_q  <= StDrain;
            end
          end else begin
            n_q <= n_q + CW'(1);
          end
        end
        StDrain: begin
          if (k_q == nout_q) begin
            j_q     <= '0;
            state_q <= StUnload;
          end
        end
        StUnload: begin
          if (r_ready) begin
            j_q <= j_q + CW'(1);
            if (last_res) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (x_hs) xbuf[ld_cnt_q[IW-1:0]] <= x_data;
    if (capture) ybuf[k_q[IW-1:0]] <= y_data;
  end

  assign x_ready    = (state_q == StLoad);
  assign w_rd       = (state_q == StStream);
  assign w_addr     = w_addr_q;
  assign pair_valid = pair_valid_q;
  assign a_out      = pair_valid_q ? w_data : '0;
  assign x_out      = x_out_q;
  assign row_first  = row_first_q;
  assign row_last   = row_last_q;
  assign r_valid    = (state_q == StUnload);
  assign r_data     = r_valid ? ybuf[j_q[IW-1:0]] : '0;
  assign busy       = (state_q != StIdle);
  assign done       = r_valid && r_ready && last_res;

endmodule

// File: tb/tb_mxm_operand_streamer.sv
// Randomized bench for mxm_operand_streamer: a queue-based model of the layer
// (expected pair stream and result stream) checked every cycle, plus literal pins.
module tb_mxm_operand_streamer;

  localparam int W = 8, NMAX = 16, AW = 8, CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_nin, cfg_nout;
  logic          x_valid;
  logic [W-1:0]  x_data;
  logic          x_ready;
  logic          w_rd;
  logic [AW-1:0] w_addr;
  logic [W-1:0]  w_data;
  logic          pair_valid;
  logic [W-1:0]  a_out, x_out;
  logic          row_first, row_last;
  logic          y_valid;
  logic [W-1:0]  y_data;
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic          r_ready;
  logic          busy, done;

  always #5 clk = ~clk;

  mxm_operand_streamer #(.W(W), .NMAX(NMAX), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_nin(cfg_nin), .cfg_nout(cfg_nout),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .pair_valid(pair_valid), .a_out(a_out), .x_out(x_out),
    .row_first(row_first), .row_last(row_last),
    .y_valid(y_valid), .y_data(y_data),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] x;
    logic         f;
    logic         l;
  } pair_t;

  logic [W-1:0] mem [256];
  logic [W-1:0] xv [NMAX];
  logic [W-1:0] yv [20];

  pair_t        exp_pairs[$];
  logic [W-1:0] exp_res[$];
  pair_t        obs_pairs[$];
  logic [W-1:0] obs_res[$];

  int n_cmp = 0, n_bad = 0;
  int exp_addr, wrd_cnt, first_wrd, last_wrd, max_addr, done_cnt;
  int cyc = 0;
  bit prev_wrd = 1'b0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Weight memory: read data valid one cycle after the strobe.
  always @(posedge clk) if (w_rd) w_data <= mem[w_addr];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      if (w_rd) begin
        chk("w_addr", 32'(w_addr), 32'(exp_addr));
        if (wrd_cnt == 0) first_wrd = cyc;
        last_wrd = cyc;
        wrd_cnt++;
        exp_addr++;
        if (int'(w_addr) > max_addr) max_addr = int'(w_addr);
      end
      chk("pair_align", 32'(pair_valid), 32'(prev_wrd));
      prev_wrd = w_rd;
      if (pair_valid) begin
        pair_t got;
        got.a = a_out; got.x = x_out; got.f = row_first; got.l = row_last;
        obs_pairs.push_back(got);
        chk("pair_expected", 32'(exp_pairs.size() != 0), 32'(1));
        if (exp_pairs.size() != 0) begin
          pair_t p;
          p = exp_pairs.pop_front();
          chk("a_out", 32'(a_out), 32'(p.a));
          chk("x_out", 32'(x_out), 32'(p.x));
          chk("row_first", 32'(row_first), 32'(p.f));
          chk("row_last", 32'(row_last), 32'(p.l));
        end
      end
      if (r_valid) begin
        chk("res_expected", 32'(exp_res.size() != 0), 32'(1));
        if (exp_res.size() != 0) begin
          chk("r_data", 32'(r_data), 32'(exp_res[0]));
          chk("done", 32'(done), 32'(r_ready && exp_res.size() == 1));
          if (r_ready) begin
            obs_res.push_back(r_data);
            void'(exp_res.pop_front());
          end
        end
      end else begin
        chk("done_quiet", 32'(done), 32'(0));
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_x_ready"}, 32'(x_ready), 32'(0));
    chk({tag, "_w_rd"}, 32'(w_rd), 32'(0));
    chk({tag, "_w_addr"}, 32'(w_addr), 32'(0));
    chk({tag, "_pair_valid"}, 32'(pair_valid), 32'(0));
    chk({tag, "_a_out"}, 32'(a_out), 32'(0));
    chk({tag, "_x_out"}, 32'(x_out), 32'(0));
    chk({tag, "_row_first"}, 32'(row_first), 32'(0));
    chk({tag, "_row_last"}, 32'(row_last), 32'(0));
    chk({tag, "_r_valid"}, 32'(r_valid), 32'(0));
    chk({tag, "_r_data"}, 32'(r_data), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // Build the expected layer from mem/xv/yv, issue start and load the activations.
  task automatic launch(input int nin, input int nout);
    int i, c;
    exp_pairs.delete(); exp_res.delete(); obs_pairs.delete(); obs_res.delete();
    exp_addr = 0; wrd_cnt = 0; max_addr = 0; done_cnt = 0; first_wrd = 0; last_wrd = 0;
    for (int m = 0; m < nout; m++)
      for (int n = 0; n < nin; n++) begin
        pair_t p;
        p.a = mem[m * nin + n]; p.x = xv[n]; p.f = (n == 0); p.l = (n == nin - 1);
        exp_pairs.push_back(p);
      end
    for (int k = 0; k < nout; k++) exp_res.push_back(yv[k]);
    start = 1'b1; cfg_nin = CW'(nin); cfg_nout = CW'(nout);
    @(posedge clk); #1;
    start = 1'b0; cfg_nin = CW'($urandom); cfg_nout = CW'($urandom);
    @(negedge clk);
    chk("x_ready_load", 32'(x_ready), 32'(1));
    chk("busy_load", 32'(busy), 32'(1));
    @(posedge clk); #1;
    i = 0; c = 0;
    while (i < nin && c < 500) begin
      x_valid = ($urandom_range(0, 2) != 0);
      x_data  = xv[i];
      @(negedge clk);
      if (x_valid && x_ready) i++;
      @(posedge clk); #1;
      c++;
    end
    x_valid = 1'b0;
    chk("x_loaded", 32'(i), 32'(nin));
  endtask

  task automatic finish_layer(input int nin, input int nout, input int ny, input bit drain_ys,
                              input bit rand_rdy, input int hold, input bit poke);
    bit got_done;
    int yc, rc, h;
    got_done = 1'b0; yc = 0; rc = 0; h = hold;
    fork
      begin
        if (drain_ys) while (w_rd && yc < 2000) begin @(posedge clk); #1; yc++; end
        for (int i = 0; i < ny; i++) begin
          if (!drain_ys) repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          y_valid = 1'b1; y_data = yv[i];
          @(posedge clk); #1;
          y_valid = 1'b0;
        end
      end
      begin
        while (!got_done && rc < 3000) begin
          r_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (r_valid && h > 0) begin r_ready = 1'b0; h--; end
          @(negedge clk);
          if (done) got_done = 1'b1;
          @(posedge clk); #1;
          rc++;
        end
        r_ready = 1'b0;
      end
      begin
        if (poke) begin
          repeat (20) begin @(posedge clk); #1; end
          start = 1'b1; cfg_nin = CW'(2); cfg_nout = CW'(2);
          @(posedge clk); #1;
          start = 1'b0; cfg_nin = CW'(0);
        end
      end
    join
    chk("done_seen", 32'(got_done), 32'(1));
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'(0));
    chk("r_valid_after", 32'(r_valid), 32'(0));
    chk("pairs_left", 32'(exp_pairs.size()), 32'(0));
    chk("res_left", 32'(exp_res.size()), 32'(0));
    chk("done_count", 32'(done_cnt), 32'(1));
    chk("wrd_count", 32'(wrd_cnt), 32'(nin * nout));
    chk("wrd_span", 32'(last_wrd - first_wrd + 1), 32'(nin * nout));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b0; start = 1'b0; cfg_nin = '0; cfg_nout = '0;
    x_valid = 1'b0; x_data = '0; y_valid = 1'b0; y_data = '0; r_ready = 1'b0;
    w_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("por");
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset in the middle of STREAM.
    for (int a = 0; a < 256; a++) mem[a] = W'($urandom);
    for (int i = 0; i < NMAX; i++) xv[i] = W'($urandom);
    launch(4, 4);
    c = 0;
    while (w_addr != 8'd5 && c < 100) begin @(posedge clk); #1; c++; end
    chk("mid_stream_reached", 32'(w_addr), 32'(5));
    chk_en = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_zero("rst_hold");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("rst_release");
    exp_pairs.delete(); exp_res.delete(); prev_wrd = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Basic layer nin=4 nout=2 with a stalled result stream.
    for (int a = 0; a < 256; a++) mem[a] = W'(a + 10);
    for (int i = 0; i < 4; i++) xv[i] = W'(i + 1);
    yv[0] = 8'd5; yv[1] = 8'd9;
    launch(4, 2);
    finish_layer(4, 2, 2, 1'b0, 1'b0, 3, 1'b0);
    chk("basic_npairs", 32'(obs_pairs.size()), 32'(8));
    if (obs_pairs.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("basic_a", 32'(obs_pairs[i].a), 32'(10 + i));
        chk("basic_x", 32'(obs_pairs[i].x), 32'((i % 4) + 1));
        chk("basic_first", 32'(obs_pairs[i].f), 32'(i == 0 || i == 4));
        chk("basic_last", 32'(obs_pairs[i].l), 32'(i == 3 || i == 7));
      end
    chk("basic_nres", 32'(obs_res.size()), 32'(2));
    if (obs_res.size() == 2) begin
      chk("basic_res0", 32'(obs_res[0]), 32'(5));
      chk("basic_res1", 32'(obs_res[1]), 32'(9));
    end

    // Degenerate 1x1 layer.
    mem[0] = 8'd3; xv[0] = 8'd7; yv[0] = 8'h42;
    launch(1, 1);
    finish_layer(1, 1, 1, 1'b0, 1'b1, 0, 1'b0);
    chk("deg_npairs", 32'(obs_pairs.size()), 32'(1));
    if (obs_pairs.size() == 1) begin
      chk("deg_a", 32'(obs_pairs[0].a), 32'(3));
      chk("deg_x", 32'(obs_pairs[0].x), 32'(7));
      chk("deg_first", 32'(obs_pairs[0].f), 32'(1));
      chk("deg_last", 32'(obs_pairs[0].l), 32'(1));
    end
    chk("deg_nres", 32'(obs_res.size()), 32'(1));

    // Illegal configurations are ignored.
    start = 1'b1; cfg_nin = CW'(0); cfg_nout = CW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("illegal_nin_busy", 32'(busy), 32'(0));
    chk("illegal_nin_x_ready", 32'(x_ready), 32'(0));
    @(posedge clk); #1;
    start = 1'b1; cfg_nin = CW'(3); cfg_nout = CW'(NMAX + 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("illegal_nout_busy", 32'(busy), 32'(0));
    chk("illegal_nout_x_ready", 32'(x_ready), 32'(0));
    @(posedge clk); #1;

    // Maximum size, 17 results delivered in DRAIN, start poked during STREAM.
    for (int a = 0; a < 256; a++) mem[a] = W'($urandom);
    for (int i = 0; i < NMAX; i++) xv[i] = W'($urandom);
    for (int i = 0; i < 20; i++) yv[i] = W'(100 + i);
    launch(NMAX, NMAX);
    finish_layer(NMAX, NMAX, 17, 1'b1, 1'b1, 0, 1'b1);
    chk("max_addr", 32'(max_addr), 32'(255));
    chk("max_npairs", 32'(obs_pairs.size()), 32'(256));
    chk("max_nres", 32'(obs_res.size()), 32'(16));
    if (obs_res.size() == 16) chk("max_last_res", 32'(obs_res[15]), 32'(115));

    // Random layers.
    for (int t = 0; t < 5; t++) begin
      int nin, nout;
      nin = $urandom_range(1, NMAX);
      nout = $urandom_range(1, NMAX);
      for (int a = 0; a < 256; a++) mem[a] = W'($urandom);
      for (int i = 0; i < NMAX; i++) xv[i] = W'($urandom);
      for (int i = 0; i < 20; i++) yv[i] = W'($urandom);
      launch(nin, nout);
      finish_layer(nin, nout, nout + $urandom_range(0, 2), 1'b0, 1'b1, $urandom_range(0, 2),
                   1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mxm_operand_streamer.md
Name: mxm_operand_streamer

Overview:
Feeder for the serial MAC/ReLU datapath. Loads an input activation vector, walks a weight memory in row-major order, and emits aligned (weight, activation) pairs with row-boundary flags. It collects the per-row results returned by the datapath into a result buffer, then drains them over a valid/ready stream. One full layer runs per start command.

Parameters:
W, 8, data bit-width of weights, activations and results
NMAX, 16, maximum vector length and maximum row count (buffer depth)
AW, 8, weight memory address width; must satisfy 2^AW >= NMAX*NMAX
CW, 5, width of dimension fields; must satisfy 2^CW > NMAX

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-low
start  in  1  one-cycle command pulse; sampled only in IDLE
cfg_nin  in  CW  input vector length, legal range 1..NMAX
cfg_nout  in  CW  output row count, legal range 1..NMAX
x_valid  in  1  activation input valid
x_data  in  W  activation input
x_ready  out  1  high only in LOAD
w_rd  out  1  weight memory read strobe
w_addr  out  AW  weight memory address
w_data  in  W  weight memory read data; valid 1 cycle after w_rd
pair_valid  out  1  A/X pair valid; consumer accepts every cycle, no backpressure
a_out  out  W  weight operand
x_out  out  W  activation operand
row_first  out  1  qualifies the first pair of a row (accumulator clear)
row_last  out  1  qualifies the last pair of a row
y_valid  in  1  result returned from datapath
y_data  in  W  result value
r_valid  out  1  result stream valid
r_data  out  W  result stream data
r_ready  in  1  result stream ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last result is accepted

Behaviour:
- Reset (rst=0 at edge): state=IDLE, all counters 0. x_ready, w_rd, pair_valid, row_first, row_last, r_valid, busy and done are 0. w_addr, a_out, x_out and r_data are 0. Buffer contents are don't-care. Reset mid-operation aborts immediately and emits no done.
- IDLE: on start with 1<=cfg_nin<=NMAX and 1<=cfg_nout<=NMAX, latch both dimensions and go to LOAD. An illegal start is ignored and the block stays IDLE.
- LOAD: x_ready=1. Each x_valid&x_ready handshake writes xbuf[i], i++. After handshake number nin, go to STREAM next cycle.
- STREAM: one w_rd per cycle for nout*nin consecutive cycles. w_addr runs from 0 to nout*nin-1 and is a running counter, not a multiply. Index counters run n=0..nin-1 (inner) and m=0..nout-1 (outer).
- Pair output is delayed exactly 1 cycle from the w_rd cycle.
  - pair_valid=1 and a_out=w_data.
  - x_out=xbuf[n] is registered so it aligns with w_data.
  - row_first = (n==0); row_last = (n==nin-1). Both are high together when nin=1.
- After the final w_rd, go to DRAIN. The last pair emerges in the first DRAIN cycle.
- Result capture is active in STREAM and DRAIN. Each y_valid writes ybuf[k], k++. y_valid in any other state is ignored. Results beyond nout are dropped. k is not bounded by datapath latency.
- DRAIN: once k==nout and the last pair has been emitted, go to UNLOAD. The block waits indefinitely for results.
- UNLOAD: r_valid=1 and r_data=ybuf[j]. On r_valid&r_ready, j++. The accept of j=nout-1 pulses done the same cycle and returns to IDLE next cycle.
- r_data holds stable while r_valid&~r_ready.
- start outside IDLE is ignored.
- cfg_* changes after latch have no effect.
- Widths: w_addr wraps modulo 2^AW (parameter constraint prevents wrap for legal dims). No arithmetic on data paths; all data paths are pure W-bit moves.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-STREAM, then rst=1 -> all outputs 0, state IDLE, no done; a following start runs a full layer normally.
- Basic layer, nin=4, nout=2: x={1,2,3,4}, mem[a]=a+10 -> 8 pairs a_out=10..17, x_out=1,2,3,4,1,2,3,4; row_first on pairs 0 and 4, row_last on pairs 3 and 7; w_rd spans exactly 8 cycles.
- Result path: return y=5 and y=9 at arbitrary delays, hold r_ready=0 for 3 cycles -> r_data=5 held stable, then 5 and 9 on two accepts; done pulses on the accept of 9 only.
- Degenerate nin=1, nout=1: x={7}, mem[0]=3 -> a single pair with row_first=row_last=1; one y accepted, then done.
- Illegal config: start with cfg_nin=0, then with cfg_nout=NMAX+1 -> busy stays 0 and x_ready stays 0.
- Maximum size nin=nout=16: w_addr reaches 255 with no wrap; 256 pairs emitted; 17 y_valid pulses in DRAIN -> only the first 16 stored; a start asserted during STREAM is ignored.
